// File: rtl/core_dbus_axil_bridge_pkg.sv
// Shared AXI-Lite constants, FSM state encoding and response helper for the
// core data-bus to AXI4-Lite bridge.
package core_dbus_axil_bridge_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR      = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_ADDR = 3'd3,
        ST_RD_DATA = 3'd4,
        ST_DONE    = 3'd5
    } bridge_state_t;

    // Any response other than OKAY is reported to the core as an error.
    function automatic logic resp_is_err(input logic [1:0] resp);
        case (resp)
            AXI_RESP_OKAY:                                    return 1'b0;
            AXI_RESP_EXOKAY, AXI_RESP_SLVERR, AXI_RESP_DECERR: return 1'b1;
            default:                                          return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/core_dbus_axil_bridge_wr_channel_ctrl.sv
// Tracks the independent AW and W handshakes of one write and reports when
// both have completed (including a handshake happening this cycle).
module core_dbus_axil_bridge_wr_channel_ctrl (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic aw_hs,
    input  logic w_hs,
    output logic aw_done,
    output logic w_done,
    output logic both_done
);

    logic aw_q;
    logic w_q;

    // Flags live only while the FSM sits in WR; any other state clears them.
    always_ff @(posedge clk) begin
        if (rst || !active) begin
            aw_q <= 1'b0;
            w_q  <= 1'b0;
        end else begin
            if (aw_hs) aw_q <= 1'b1;
            if (w_hs)  w_q  <= 1'b1;
        end
    end

    assign aw_done   = aw_q;
    assign w_done    = w_q;
    assign both_done = (aw_q || aw_hs) && (w_q || w_hs);

endmodule

// File: rtl/core_dbus_axil_bridge.sv
// Single-outstanding AXI4-Lite master for the core's data-memory port; stalls
// the pipeline until the bus transfer completes, with an optional watchdog.
module core_dbus_axil_bridge
    import core_dbus_axil_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ram_ce_i,
    input  logic                  ram_write_en_i,
    input  logic [31:0]           ram_addr_i,
    input  logic [DATA_WIDTH-1:0] ram_write_data_i,
    input  logic [3:0]            ram_sel_i,
    output logic [DATA_WIDTH-1:0] ram_read_data_o,
    output logic                  stall_req_o,
    output logic                  err_o,
    output logic [2:0]            dbg_state,
    output logic [ADDR_WIDTH-1:0] m_awaddr,
    output logic [2:0]            m_awprot,
    output logic                  m_awvalid,
    input  logic                  m_awready,
    output logic [DATA_WIDTH-1:0] m_wdata,
    output logic [3:0]            m_wstrb,
    output logic                  m_wvalid,
    input  logic                  m_wready,
    input  logic [1:0]            m_bresp,
    input  logic                  m_bvalid,
    output logic                  m_bready,
    output logic [ADDR_WIDTH-1:0] m_araddr,
    output logic [2:0]            m_arprot,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    input  logic [1:0]            m_rresp,
    input  logic                  m_rvalid,
    output logic                  m_rready
);

    // Handshake rule: a transfer happens on a channel in any cycle where its
    // valid and ready are both high; valids are derived only from state and
    // registered flags, never from a ready, and hold with stable payload.

    bridge_state_t         state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [3:0]            sel_q;
    logic                  err_q;
    logic [31:0]           wd_cnt;
    logic                  busy, timeout;
    logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic                  aw_done, w_done, wr_both_done;

    assign busy    = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign timeout = (TIMEOUT_CYCLES > 0) && busy && (wd_cnt == 32'(TIMEOUT_CYCLES));

    assign aw_hs = m_awvalid && m_awready;
    assign w_hs  = m_wvalid && m_wready;
    assign b_hs  = m_bvalid && m_bready;
    assign ar_hs = m_arvalid && m_arready;
    assign r_hs  = m_rvalid && m_rready;

    core_dbus_axil_bridge_wr_channel_ctrl u_wr_ctrl (
        .clk       (clk),
        .rst       (rst),
        .active    (state_q == ST_WR),
        .aw_hs     (aw_hs),
        .w_hs      (w_hs),
        .aw_done   (aw_done),
        .w_done    (w_done),
        .both_done (wr_both_done)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (ram_ce_i) begin
                    if (!ram_write_en_i)      state_d = ST_RD_ADDR;
                    else if (ram_sel_i != 0)  state_d = ST_WR;
                    else                      state_d = ST_DONE;
                end
            end
            ST_WR:      if (timeout) state_d = ST_DONE; else if (wr_both_done) state_d = ST_WR_RESP;
            ST_WR_RESP: if (timeout || b_hs) state_d = ST_DONE;
            ST_RD_ADDR: if (timeout) state_d = ST_DONE; else if (ar_hs) state_d = ST_RD_DATA;
            ST_RD_DATA: if (timeout || r_hs) state_d = ST_DONE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        m_awvalid   = (state_q == ST_WR) && !aw_done && !timeout;
        m_wvalid    = (state_q == ST_WR) && !w_done && !timeout;
        m_bready    = (state_q == ST_WR_RESP) && !timeout;
        m_arvalid   = (state_q == ST_RD_ADDR) && !timeout;
        m_rready    = (state_q == ST_RD_DATA) && !timeout;
        stall_req_o = ram_ce_i && (state_q != ST_DONE);
        err_o       = (state_q == ST_DONE) && err_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q          <= '0;
            data_q          <= '0;
            sel_q           <= '0;
            err_q           <= 1'b0;
            wd_cnt          <= '0;
            ram_read_data_o <= '0;
        end else begin
            if (state_q == ST_IDLE) begin
                wd_cnt <= '0;
                if (ram_ce_i) begin
                    addr_q <= ram_addr_i[ADDR_WIDTH-1:0];
                    data_q <= ram_write_data_i;
                    sel_q  <= ram_sel_i;
                end
            end else if (busy) begin
                wd_cnt <= wd_cnt + 32'd1;
            end

            if (timeout)                 err_q <= 1'b1;
            else if (b_hs)               err_q <= resp_is_err(m_bresp);
            else if (r_hs)               err_q <= resp_is_err(m_rresp);
            else if (state_q == ST_IDLE) err_q <= 1'b0;

            // Read data is taken even on an error response; a timed-out load returns 0.
            if (r_hs)
                ram_read_data_o <= m_rdata;
            else if (timeout && (state_q == ST_RD_ADDR || state_q == ST_RD_DATA))
                ram_read_data_o <= '0;
        end
    end

    assign m_awaddr  = addr_q;
    assign m_wdata   = data_q;
    assign m_wstrb   = sel_q;
    assign m_araddr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign m_awprot  = AXI_PROT_DEFAULT;
    assign m_arprot  = AXI_PROT_DEFAULT;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_core_dbus_axil_bridge.sv
// Directed bench for core_dbus_axil_bridge: loads, stores, error responses,
// watchdog timeout and reset during a transfer.
module tb_core_dbus_axil_bridge;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR      = 3'd1;
    localparam logic [2:0] S_WR_RESP = 3'd2;
    localparam logic [2:0] S_RD_ADDR = 3'd3;
    localparam logic [2:0] S_RD_DATA = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic        clk = 1'b0;
    logic        rst;
    logic        ram_ce_i, ram_write_en_i;
    logic [31:0] ram_addr_i, ram_write_data_i;
    logic [3:0]  ram_sel_i;
    logic [31:0] ram_read_data_o;
    logic        stall_req_o, err_o;
    logic [2:0]  dbg_state;
    logic [31:0] m_awaddr, m_araddr, m_wdata, m_rdata;
    logic [2:0]  m_awprot, m_arprot;
    logic        m_awvalid, m_awready, m_wvalid, m_wready;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_bresp, m_rresp;
    logic        m_bvalid, m_bready, m_arvalid, m_arready, m_rvalid, m_rready;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    core_dbus_axil_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .ram_ce_i(ram_ce_i), .ram_write_en_i(ram_write_en_i), .ram_addr_i(ram_addr_i),
        .ram_write_data_i(ram_write_data_i), .ram_sel_i(ram_sel_i),
        .ram_read_data_o(ram_read_data_o), .stall_req_o(stall_req_o), .err_o(err_o),
        .dbg_state(dbg_state),
        .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    task automatic idle_inputs();
        ram_ce_i = 0; ram_write_en_i = 0; ram_addr_i = 0; ram_write_data_i = 0; ram_sel_i = 0;
        m_awready = 0; m_wready = 0; m_bresp = 0; m_bvalid = 0;
        m_arready = 0; m_rdata = 0; m_rresp = 0; m_rvalid = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        idle_inputs();
        repeat (3) @(negedge clk);
        checks++;
        if ({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready} !== 5'b0) begin
            errors++; $display("FAIL reset_handshakes: got %b expected 00000",
                               {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready});
        end
        checks++;
        if (dbg_state !== S_IDLE || ram_read_data_o !== 32'h0 || err_o !== 1'b0 || stall_req_o !== 1'b0) begin
            errors++; $display("FAIL reset_state: state=%0d rdata=%h err=%b stall=%b expected 0/0/0/0",
                               dbg_state, ram_read_data_o, err_o, stall_req_o);
        end
        rst = 0;
    endtask

    task automatic test_load();
        @(negedge clk);
        ram_ce_i = 1; ram_write_en_i = 0; ram_addr_i = 32'h0000_1006; ram_sel_i = 4'hf;
        #1;
        checks++;
        if (stall_req_o !== 1'b1) begin
            errors++; $display("FAIL load_stall_idle: got %b expected 1", stall_req_o);
        end
        @(negedge clk);
        checks++;
        if (m_arvalid !== 1'b1 || m_araddr !== 32'h0000_1004 || m_arprot !== 3'b000 || stall_req_o !== 1'b1) begin
            errors++; $display("FAIL load_ar: arvalid=%b araddr=%h arprot=%b stall=%b expected 1/00001004/000/1",
                               m_arvalid, m_araddr, m_arprot, stall_req_o);
        end
        m_arready = 1;
        @(negedge clk);
        m_arready = 0;
        checks++;
        if (m_arvalid !== 1'b0 || m_rready !== 1'b1 || stall_req_o !== 1'b1) begin
            errors++; $display("FAIL load_r: arvalid=%b rready=%b stall=%b expected 0/1/1",
                               m_arvalid, m_rready, stall_req_o);
        end
        m_rvalid = 1; m_rdata = 32'hDEAD_BEEF; m_rresp = 2'b00;
        @(negedge clk);
        m_rvalid = 0;
        checks++;
        if (dbg_state !== S_DONE || stall_req_o !== 1'b0 || ram_read_data_o !== 32'hDEAD_BEEF || err_o !== 1'b0) begin
            errors++; $display("FAIL load_done: state=%0d stall=%b rdata=%h err=%b expected 5/0/deadbeef/0",
                               dbg_state, stall_req_o, ram_read_data_o, err_o);
        end
        ram_ce_i = 0;
        @(negedge clk);
        checks++;
        if (dbg_state !== S_IDLE || ram_read_data_o !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL load_hold: state=%0d rdata=%h expected 0/deadbeef", dbg_state, ram_read_data_o);
        end
    endtask

    task automatic test_store_split();
        @(negedge clk);
        ram_ce_i = 1; ram_write_en_i = 1; ram_addr_i = 32'h0000_2000;
        ram_write_data_i = 32'h1234_5678; ram_sel_i = 4'b0011;
        @(negedge clk);
        checks++;
        if (m_awvalid !== 1'b1 || m_wvalid !== 1'b1 || m_awaddr !== 32'h0000_2000 ||
            m_wdata !== 32'h1234_5678 || m_wstrb !== 4'b0011 || m_bready !== 1'b0) begin
            errors++; $display("FAIL store_entry: awv=%b wv=%b awaddr=%h wdata=%h wstrb=%b bready=%b",
                               m_awvalid, m_wvalid, m_awaddr, m_wdata, m_wstrb, m_bready);
        end
        m_wready = 1;
        @(negedge clk);
        m_wready = 0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (m_wvalid !== 1'b0 || m_awvalid !== 1'b1 || m_awaddr !== 32'h0000_2000 ||
                m_bready !== 1'b0 || dbg_state !== S_WR) begin
                errors++; $display("FAIL store_aw_wait%0d: wv=%b awv=%b awaddr=%h bready=%b state=%0d expected 0/1/00002000/0/1",
                                   i, m_wvalid, m_awvalid, m_awaddr, m_bready, dbg_state);
            end
            if (i == 2) m_awready = 1;
            else @(negedge clk);
        end
        @(negedge clk);
        m_awready = 0;
        checks++;
        if (m_awvalid !== 1'b0 || m_wvalid !== 1'b0 || m_bready !== 1'b1 || dbg_state !== S_WR_RESP) begin
            errors++; $display("FAIL store_bresp: awv=%b wv=%b bready=%b state=%0d expected 0/0/1/2",
                               m_awvalid, m_wvalid, m_bready, dbg_state);
        end
        m_bvalid = 1; m_bresp = 2'b00;
        @(negedge clk);
        m_bvalid = 0;
        checks++;
        if (dbg_state !== S_DONE || stall_req_o !== 1'b0 || err_o !== 1'b0 || m_bready !== 1'b0) begin
            errors++; $display("FAIL store_done: state=%0d stall=%b err=%b bready=%b expected 5/0/0/0",
                               dbg_state, stall_req_o, err_o, m_bready);
        end
        ram_ce_i = 0;
        @(negedge clk);
    endtask

    task automatic test_store_nosel();
        int seen_valid;
        seen_valid = 0;
        @(negedge clk);
        ram_ce_i = 1; ram_write_en_i = 1; ram_addr_i = 32'h0000_3000;
        ram_write_data_i = 32'hCAFE_F00D; ram_sel_i = 4'b0000;
        #1;
        if (m_awvalid || m_wvalid) seen_valid++;
        checks++;
        if (stall_req_o !== 1'b1) begin
            errors++; $display("FAIL nosel_stall_first: got %b expected 1", stall_req_o);
        end
        @(negedge clk);
        if (m_awvalid || m_wvalid) seen_valid++;
        checks++;
        if (dbg_state !== S_DONE || stall_req_o !== 1'b0 || err_o !== 1'b0) begin
            errors++; $display("FAIL nosel_done: state=%0d stall=%b err=%b expected 5/0/0",
                               dbg_state, stall_req_o, err_o);
        end
        ram_ce_i = 0;
        @(negedge clk);
        if (m_awvalid || m_wvalid) seen_valid++;
        checks++;
        if (seen_valid !== 0 || dbg_state !== S_IDLE) begin
            errors++; $display("FAIL nosel_no_bus: valid_cycles=%0d state=%0d expected 0/0", seen_valid, dbg_state);
        end
    endtask

    task automatic test_read_err();
        @(negedge clk);
        ram_ce_i = 1; ram_write_en_i = 0; ram_addr_i = 32'h0000_0040; ram_sel_i = 4'hf;
        @(negedge clk);
        m_arready = 1;
        @(negedge clk);
        m_arready = 0;
        m_rvalid = 1; m_rdata = 32'hAAAA_5555; m_rresp = 2'b10;
        @(negedge clk);
        m_rvalid = 0; m_rresp = 2'b00;
        checks++;
        if (dbg_state !== S_DONE || err_o !== 1'b1 || ram_read_data_o !== 32'hAAAA_5555) begin
            errors++; $display("FAIL rderr_done: state=%0d err=%b rdata=%h expected 5/1/aaaa5555",
                               dbg_state, err_o, ram_read_data_o);
        end
        ram_ce_i = 0;
        @(negedge clk);
        checks++;
        if (err_o !== 1'b0 || dbg_state !== S_IDLE) begin
            errors++; $display("FAIL rderr_pulse: err=%b state=%0d expected 0/0", err_o, dbg_state);
        end
    endtask

    task automatic test_ce_drop();
        @(negedge clk);
        ram_ce_i = 1; ram_write_en_i = 0; ram_addr_i = 32'h0000_0033; ram_sel_i = 4'hf;
        @(negedge clk);
        m_arready = 1;
        @(negedge clk);
        m_arready = 0;
        ram_ce_i = 0;
        #1;
        checks++;
        if (stall_req_o !== 1'b0 || dbg_state !== S_RD_DATA || m_rready !== 1'b1) begin
            errors++; $display("FAIL cedrop_mid: stall=%b state=%0d rready=%b expected 0/4/1",
                               stall_req_o, dbg_state, m_rready);
        end
        m_rvalid = 1; m_rdata = 32'h0BAD_F00D;
        @(negedge clk);
        m_rvalid = 0;
        checks++;
        if (dbg_state !== S_DONE || ram_read_data_o !== 32'h0BAD_F00D) begin
            errors++; $display("FAIL cedrop_done: state=%0d rdata=%h expected 5/0badf00d", dbg_state, ram_read_data_o);
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int high_cycles;
        high_cycles = 0;
        @(negedge clk);
        ram_ce_i = 1; ram_write_en_i = 0; ram_addr_i = 32'h0000_0100; ram_sel_i = 4'hf;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_arvalid === 1'b1) high_cycles++;
            else break;
        end
        checks++;
        if (high_cycles !== 8) begin
            errors++; $display("FAIL timeout_arvalid_len: got %0d cycles expected 8", high_cycles);
        end
        @(negedge clk);
        checks++;
        if (dbg_state !== S_DONE || err_o !== 1'b1 || ram_read_data_o !== 32'h0 || m_arvalid !== 1'b0) begin
            errors++; $display("FAIL timeout_done: state=%0d err=%b rdata=%h arvalid=%b expected 5/1/0/0",
                               dbg_state, err_o, ram_read_data_o, m_arvalid);
        end
        ram_ce_i = 0;
        @(negedge clk);
        checks++;
        if (dbg_state !== S_IDLE || err_o !== 1'b0) begin
            errors++; $display("FAIL timeout_idle: state=%0d err=%b expected 0/0", dbg_state, err_o);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        ram_ce_i = 1; ram_write_en_i = 1; ram_addr_i = 32'h0000_4008;
        ram_write_data_i = 32'h5A5A_A5A5; ram_sel_i = 4'b1111;
        @(negedge clk);
        m_awready = 1; m_wready = 1;
        @(negedge clk);
        m_awready = 0; m_wready = 0;
        checks++;
        if (dbg_state !== S_WR_RESP || m_bready !== 1'b1 || m_awvalid !== 1'b0 || m_wvalid !== 1'b0) begin
            errors++; $display("FAIL both_hs_same_cycle: state=%0d bready=%b awv=%b wv=%b expected 2/1/0/0",
                               dbg_state, m_bready, m_awvalid, m_wvalid);
        end
        rst = 1; ram_ce_i = 0;
        @(negedge clk);
        rst = 0;
        checks++;
        if (dbg_state !== S_IDLE || stall_req_o !== 1'b0 ||
            {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready} !== 5'b0) begin
            errors++; $display("FAIL reset_mid: state=%0d stall=%b hs=%b expected 0/0/00000",
                               dbg_state, stall_req_o, {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready});
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_store_split();
        test_store_nosel();
        test_read_err();
        test_ce_drop();
        test_timeout();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
